// File: rtl/axi_ic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ic_pkg
// Description : Shared types and constants for the AXI interconnect read path.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RDATA  = 2'd1,
        DECERR = 2'd2
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam int         SLV_SEL_W   = 3;
    localparam int         MST_NUM     = 2;

endpackage : axi_ic_pkg
`default_nettype wire

// File: rtl/axi_rd_decerr_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_decerr_slave
// Description : Internal default slave; answers unmapped reads with a DECERR burst.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_decerr_slave
    import axi_ic_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              i_load,
    input  logic [ID_W-1:0]   i_id,
    input  logic [7:0]        i_len,
    input  logic              i_active,
    input  logic              i_rready,
    output logic              o_rvalid,
    output logic              o_rlast,
    output logic [ID_W-1:0]   o_rid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp
);

    logic [7:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;

    // cnt holds the number of beats still to follow the current one
    always_comb begin
        cnt_d = cnt_q;
        id_d  = id_q;
        if (i_load) begin
            cnt_d = i_len;
            id_d  = i_id;
        end else if (i_active && i_rready && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= 8'd0;
            id_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            id_q  <= id_d;
        end
    end

    assign o_rvalid = i_active;
    assign o_rlast  = i_active && (cnt_q == 8'd0);
    assign o_rid    = i_active ? id_q : '0;
    assign o_rdata  = '0;
    assign o_rresp  = i_active ? RESP_DECERR : RESP_OKAY;

endmodule : axi_rd_decerr_slave
`default_nettype wire

// File: rtl/axi_rd_router.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_router
// Description : Read-path router: forwards the granted master's AR to the
//               decoded slave and steers the R burst back, one read at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_router
    import axi_ic_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   m0_rgrnt,
    input  logic                   m1_rgrnt,
    input  logic [ID_W-1:0]        m0_ARID,
    input  logic [ADDR_W-1:0]      m0_ARADDR,
    input  logic [7:0]             m0_ARLEN,
    input  logic                   m0_ARVALID,
    output logic                   m0_ARREADY,
    output logic [ID_W-1:0]        m0_RID,
    output logic [DATA_W-1:0]      m0_RDATA,
    output logic [1:0]             m0_RRESP,
    output logic                   m0_RLAST,
    output logic                   m0_RVALID,
    input  logic                   m0_RREADY,
    input  logic [ID_W-1:0]        m1_ARID,
    input  logic [ADDR_W-1:0]      m1_ARADDR,
    input  logic [7:0]             m1_ARLEN,
    input  logic                   m1_ARVALID,
    output logic                   m1_ARREADY,
    output logic [ID_W-1:0]        m1_RID,
    output logic [DATA_W-1:0]      m1_RDATA,
    output logic [1:0]             m1_RRESP,
    output logic                   m1_RLAST,
    output logic                   m1_RVALID,
    input  logic                   m1_RREADY,
    output logic [ID_W-1:0]        s_ARID,
    output logic [ADDR_W-1:0]      s_ARADDR,
    output logic [7:0]             s_ARLEN,
    output logic [NSLV-1:0]        s_ARVALID,
    input  logic [NSLV-1:0]        s_ARREADY,
    input  logic [NSLV*ID_W-1:0]   s_RID,
    input  logic [NSLV*DATA_W-1:0] s_RDATA,
    input  logic [NSLV*2-1:0]      s_RRESP,
    input  logic [NSLV-1:0]        s_RLAST,
    input  logic [NSLV-1:0]        s_RVALID,
    output logic [NSLV-1:0]        s_RREADY,
    output logic                   m_RVALID,
    output logic                   m_RLAST
);

    rd_state_t            state_q, state_d;
    logic                 msel_q, msel_d;
    logic [SLV_SEL_W-1:0] ssel_q, ssel_d;

    logic                 w_run;
    logic                 w_st_idle, w_st_rdata, w_st_decerr;
    logic                 w_gnt_any, w_gm;
    logic [ID_W-1:0]      w_ar_id;
    logic [ADDR_W-1:0]    w_ar_addr;
    logic [7:0]           w_ar_len;
    logic                 w_ar_valid, w_ar_ready, w_ar_hs;
    logic [SLV_SEL_W-1:0] w_sidx;
    logic                 w_in_range, w_slv_arready;
    logic [MST_NUM-1:0]   w_m_rready;
    logic                 w_rr;

    logic                 w_s_rvalid, w_s_rlast;
    logic [ID_W-1:0]      w_s_rid;
    logic [DATA_W-1:0]    w_s_rdata;
    logic [1:0]           w_s_rresp;

    logic                 w_d_rvalid, w_d_rlast;
    logic [ID_W-1:0]      w_d_rid;
    logic [DATA_W-1:0]    w_d_rdata;
    logic [1:0]           w_d_rresp;

    logic                 w_rvalid, w_rlast;
    logic [ID_W-1:0]      w_rid;
    logic [DATA_W-1:0]    w_rdat;
    logic [1:0]           w_rresp;

    // Every output is forced low while reset is held, independent of inputs
    assign w_run       = ARESETn;
    assign w_st_idle   = (state_q == IDLE);
    assign w_st_rdata  = (state_q == RDATA);
    assign w_st_decerr = (state_q == DECERR);

    assign w_gnt_any  = m0_rgrnt | m1_rgrnt;
    assign w_gm       = ~m0_rgrnt;
    assign w_ar_id    = w_gm ? m1_ARID    : m0_ARID;
    assign w_ar_addr  = w_gm ? m1_ARADDR  : m0_ARADDR;
    assign w_ar_len   = w_gm ? m1_ARLEN   : m0_ARLEN;
    assign w_ar_valid = w_gnt_any & (w_gm ? m1_ARVALID : m0_ARVALID);
    assign w_sidx     = w_ar_addr[ADDR_W-1 -: SLV_SEL_W];
    assign w_in_range = (int'(w_sidx) < NSLV);
    assign w_ar_ready = w_in_range ? w_slv_arready : 1'b1;
    assign w_ar_hs    = w_st_idle & w_ar_valid & w_ar_ready;

    assign w_m_rready = {m1_RREADY, m0_RREADY};
    assign w_rr       = w_m_rready[msel_q];

    always_comb begin
        w_slv_arready = 1'b0;
        w_s_rvalid    = 1'b0;
        w_s_rlast     = 1'b0;
        w_s_rid       = '0;
        w_s_rdata     = '0;
        w_s_rresp     = RESP_OKAY;
        s_ARVALID     = '0;
        s_RREADY      = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (w_sidx == SLV_SEL_W'(k)) begin
                w_slv_arready = s_ARREADY[k];
            end
            if (ssel_q == SLV_SEL_W'(k)) begin
                w_s_rvalid = s_RVALID[k];
                w_s_rlast  = s_RLAST[k];
                w_s_rid    = s_RID[k*ID_W +: ID_W];
                w_s_rdata  = s_RDATA[k*DATA_W +: DATA_W];
                w_s_rresp  = s_RRESP[k*2 +: 2];
            end
            s_ARVALID[k] = w_run & w_st_idle & w_ar_valid & (w_sidx == SLV_SEL_W'(k));
            s_RREADY[k]  = w_run & w_st_rdata & w_rr & (ssel_q == SLV_SEL_W'(k));
        end
    end

    assign s_ARID     = (w_run & w_st_idle & w_gnt_any) ? w_ar_id   : '0;
    assign s_ARADDR   = (w_run & w_st_idle & w_gnt_any) ? w_ar_addr : '0;
    assign s_ARLEN    = (w_run & w_st_idle & w_gnt_any) ? w_ar_len  : '0;
    assign m0_ARREADY = w_run & w_st_idle & w_gnt_any & ~w_gm & w_ar_ready;
    assign m1_ARREADY = w_run & w_st_idle & w_gnt_any &  w_gm & w_ar_ready;

    axi_rd_decerr_slave #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W)
    ) u_decerr (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .i_load   (w_ar_hs & ~w_in_range),
        .i_id     (w_ar_id),
        .i_len    (w_ar_len),
        .i_active (w_st_decerr),
        .i_rready (w_rr),
        .o_rvalid (w_d_rvalid),
        .o_rlast  (w_d_rlast),
        .o_rid    (w_d_rid),
        .o_rdata  (w_d_rdata),
        .o_rresp  (w_d_rresp)
    );

    always_comb begin
        w_rvalid = 1'b0;
        w_rlast  = 1'b0;
        w_rid    = '0;
        w_rdat   = '0;
        w_rresp  = RESP_OKAY;
        if (w_run && w_st_rdata) begin
            w_rvalid = w_s_rvalid;
            w_rlast  = w_s_rvalid & w_s_rlast;
            w_rid    = w_s_rid;
            w_rdat   = w_s_rdata;
            w_rresp  = w_s_rresp;
        end else if (w_run && w_st_decerr) begin
            w_rvalid = w_d_rvalid;
            w_rlast  = w_d_rlast;
            w_rid    = w_d_rid;
            w_rdat   = w_d_rdata;
            w_rresp  = w_d_rresp;
        end
    end

    assign m0_RVALID = w_rvalid & ~msel_q;
    assign m0_RLAST  = w_rlast  & ~msel_q;
    assign m0_RID    = msel_q ? '0        : w_rid;
    assign m0_RDATA  = msel_q ? '0        : w_rdat;
    assign m0_RRESP  = msel_q ? RESP_OKAY : w_rresp;
    assign m1_RVALID = w_rvalid &  msel_q;
    assign m1_RLAST  = w_rlast  &  msel_q;
    assign m1_RID    = msel_q ? w_rid   : '0;
    assign m1_RDATA  = msel_q ? w_rdat  : '0;
    assign m1_RRESP  = msel_q ? w_rresp : RESP_OKAY;
    assign m_RVALID  = w_rvalid;
    assign m_RLAST   = w_rlast;

    // Grant inputs only matter in IDLE; the latched master/slave hold for the whole burst
    always_comb begin
        state_d = state_q;
        msel_d  = msel_q;
        ssel_d  = ssel_q;
        case (state_q)
            IDLE: begin
                if (w_ar_hs) begin
                    msel_d = w_gm;
                    if (w_in_range) begin
                        state_d = RDATA;
                        ssel_d  = w_sidx;
                    end else begin
                        state_d = DECERR;
                    end
                end
            end
            RDATA, DECERR: begin
                if (w_rvalid && w_rr && w_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            msel_q  <= 1'b0;
            ssel_q  <= '0;
        end else begin
            state_q <= state_d;
            msel_q  <= msel_d;
            ssel_q  <= ssel_d;
        end
    end

endmodule : axi_rd_router
`default_nettype wire

// File: tb/tb_axi_rd_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_router
// Description : Randomised bench for axi_rd_router against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_router;
    import axi_ic_pkg::*;

    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, NSLV = 4;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [1:0]            mg, marv, mrr;
    logic [ID_W-1:0]       mid   [2];
    logic [ADDR_W-1:0]     maddr [2];
    logic [7:0]            mlen  [2];
    logic [NSLV-1:0]       s_ARREADY, s_RLAST, s_RVALID;
    logic [NSLV*ID_W-1:0]  s_RID;
    logic [NSLV*DATA_W-1:0] s_RDATA;
    logic [NSLV*2-1:0]     s_RRESP;

    logic                  m0_ARREADY, m1_ARREADY, m0_RLAST, m1_RLAST, m0_RVALID, m1_RVALID;
    logic [ID_W-1:0]       m0_RID, m1_RID, s_ARID;
    logic [DATA_W-1:0]     m0_RDATA, m1_RDATA;
    logic [1:0]            m0_RRESP, m1_RRESP;
    logic [ADDR_W-1:0]     s_ARADDR;
    logic [7:0]            s_ARLEN;
    logic [NSLV-1:0]       s_ARVALID, s_RREADY;
    logic                  m_RVALID, m_RLAST;

    axi_rd_router #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .m0_rgrnt(mg[0]), .m1_rgrnt(mg[1]),
        .m0_ARID(mid[0]), .m0_ARADDR(maddr[0]), .m0_ARLEN(mlen[0]), .m0_ARVALID(marv[0]),
        .m0_ARREADY(m0_ARREADY), .m0_RID(m0_RID), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP),
        .m0_RLAST(m0_RLAST), .m0_RVALID(m0_RVALID), .m0_RREADY(mrr[0]),
        .m1_ARID(mid[1]), .m1_ARADDR(maddr[1]), .m1_ARLEN(mlen[1]), .m1_ARVALID(marv[1]),
        .m1_ARREADY(m1_ARREADY), .m1_RID(m1_RID), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP),
        .m1_RLAST(m1_RLAST), .m1_RVALID(m1_RVALID), .m1_RREADY(mrr[1]),
        .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARVALID(s_ARVALID),
        .s_ARREADY(s_ARREADY), .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
        .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
        .m_RVALID(m_RVALID), .m_RLAST(m_RLAST)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    // Transaction-level model: one outstanding burst as a queue of expected beats
    bit    active, cur_m, cur_dec;
    int    cur_slv;
    beat_t q[$];
    bit    ar_hs, r_hs;
    int    ar_m;

    // Slave stimulus models
    bit              sbusy [NSLV];
    bit              svalid[NSLV];
    logic [ID_W-1:0] sid   [NSLV];
    logic [31:0]     saddr [NSLV];
    int              slen  [NSLV];
    int              sbeat [NSLV];

    bit  rand_mode, sready_all;
    int  rr_mode;
    int  total, bad, cycle;
    int  beats[2], dec_beats, ar_cnt, dut_mlast, dut_sarv;
    int  last_r_cycle, last_ar_cycle;

    function automatic logic [31:0] fdata(input int k, input logic [31:0] a, input int b);
        return a ^ (32'(k) << 24) ^ (32'(b) * 32'h0001_0001) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic [NSLV-1:0] exp_sarv, exp_srr;
        logic [1:0]      exp_arr, exp_rvv;
        int              gm, idx;
        bit              exp_rv;
        beat_t           b;
        ar_hs = 0;
        r_hs  = 0;
        if (s_ARVALID != '0) dut_sarv++;
        if (!active) begin
            exp_sarv = '0;
            exp_arr  = 2'b00;
            if (mg != 2'b00) begin
                gm  = mg[0] ? 0 : 1;
                idx = int'(maddr[gm][31:29]);
                if (idx < NSLV) begin
                    exp_arr[gm] = s_ARREADY[idx];
                    if (marv[gm]) exp_sarv[idx] = 1'b1;
                end else begin
                    exp_arr[gm] = 1'b1;
                end
                ar_hs = marv[gm] && exp_arr[gm];
                ar_m  = gm;
                if (marv[gm]) begin
                    chk("s_araddr", s_ARADDR, maddr[gm]);
                    chk("s_arid", s_ARID, mid[gm]);
                    chk("s_arlen", s_ARLEN, mlen[gm]);
                end
            end
            chk("s_arvalid", s_ARVALID, exp_sarv);
            chk("arready", {m1_ARREADY, m0_ARREADY}, exp_arr);
            chk("idle_rvalid", {m_RVALID, m1_RVALID, m0_RVALID}, 0);
            chk("idle_rlast", m_RLAST, 0);
            chk("idle_s_rready", s_RREADY, 0);
        end else begin
            chk("busy_s_arvalid", s_ARVALID, 0);
            chk("busy_arready", {m1_ARREADY, m0_ARREADY}, 0);
            exp_rv  = cur_dec ? 1'b1 : s_RVALID[cur_slv];
            exp_rvv = 2'b00;
            exp_rvv[cur_m] = exp_rv;
            exp_srr = '0;
            if (!cur_dec) exp_srr[cur_slv] = mrr[cur_m];
            chk("rvalid", {m1_RVALID, m0_RVALID}, exp_rvv);
            chk("m_rvalid", m_RVALID, exp_rv);
            chk("s_rready", s_RREADY, exp_srr);
            if (exp_rv && q.size() > 0) begin
                b = q[0];
                chk("rid",   cur_m ? m1_RID   : m0_RID,   b.id);
                chk("rdata", cur_m ? m1_RDATA : m0_RDATA, b.data);
                chk("rresp", cur_m ? m1_RRESP : m0_RRESP, b.resp);
                chk("rlast", cur_m ? m1_RLAST : m0_RLAST, b.last);
                chk("m_rlast", m_RLAST, b.last);
                r_hs = mrr[cur_m];
                if (m_RLAST && mrr[cur_m]) dut_mlast++;
            end
        end
    endtask

    task automatic update();
        int idx;
        beat_t nb;
        if (ar_hs) begin
            idx     = int'(maddr[ar_m][31:29]);
            active  = 1;
            cur_m   = ar_m[0];
            cur_dec = (idx >= NSLV);
            cur_slv = idx;
            ar_cnt++;
            last_ar_cycle = cycle;
            for (int bi = 0; bi <= int'(mlen[ar_m]); bi++) begin
                nb.id   = mid[ar_m];
                nb.data = cur_dec ? 32'h0 : fdata(idx, maddr[ar_m], bi);
                nb.resp = cur_dec ? 2'b11 : 2'b00;
                nb.last = (bi == int'(mlen[ar_m]));
                q.push_back(nb);
            end
            if (!cur_dec) begin
                sbusy[idx]  = 1;
                svalid[idx] = 0;
                sid[idx]    = mid[ar_m];
                saddr[idx]  = maddr[ar_m];
                slen[idx]   = int'(mlen[ar_m]);
                sbeat[idx]  = 0;
            end
            marv[ar_m] = 1'b0;
        end
        if (r_hs) begin
            beats[cur_m]++;
            if (cur_dec) dec_beats++;
            if (q[0].last) last_r_cycle = cycle;
            if (!cur_dec) begin
                sbeat[cur_slv]++;
                svalid[cur_slv] = 0;
                if (q[0].last) sbusy[cur_slv] = 0;
            end
            void'(q.pop_front());
            if (q.size() == 0) active = 0;
        end
    endtask

    task automatic drive();
        if (rand_mode) begin
            mg = 2'($urandom);
            for (int m = 0; m < 2; m++) begin
                if (!marv[m] && $urandom_range(2) == 0) begin
                    marv[m]  = 1'b1;
                    maddr[m] = $urandom;
                    mlen[m]  = 8'($urandom_range(5));
                    mid[m]   = 4'($urandom);
                end
            end
        end
        case (rr_mode)
            0:       mrr = 2'($urandom);
            1:       mrr = 2'b11;
            default: mrr = ~mrr;
        endcase
        s_ARREADY = sready_all ? '1 : NSLV'($urandom);
        for (int k = 0; k < NSLV; k++) begin
            if (sbusy[k]) begin
                if (!svalid[k]) svalid[k] = 1'($urandom_range(1));
                s_RVALID[k]               = svalid[k];
                s_RID[k*ID_W +: ID_W]     = sid[k];
                s_RDATA[k*DATA_W +: DATA_W] = fdata(k, saddr[k], sbeat[k]);
                s_RRESP[k*2 +: 2]         = 2'b00;
                s_RLAST[k]                = (sbeat[k] == slen[k]);
            end else begin
                s_RVALID[k]               = 1'($urandom_range(1));
                s_RID[k*ID_W +: ID_W]     = 4'($urandom);
                s_RDATA[k*DATA_W +: DATA_W] = $urandom;
                s_RRESP[k*2 +: 2]         = 2'($urandom);
                s_RLAST[k]                = 1'($urandom_range(1));
            end
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        check_cycle();
        @(posedge ACLK);
        cycle++;
        #1;
        update();
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (active && n < budget) begin
            step();
            n++;
        end
        chk("burst_timeout", active, 0);
        step();
    endtask

    task automatic clear_model();
        active = 0;
        q.delete();
        for (int k = 0; k < NSLV; k++) begin
            sbusy[k]  = 0;
            svalid[k] = 0;
        end
        marv = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cycle = 0;
        rand_mode = 0; rr_mode = 1; sready_all = 1;
        mrr = 2'b11; s_RVALID = '0; s_RLAST = '0; s_RID = '0; s_RDATA = '0; s_RRESP = '0;
        for (int m = 0; m < 2; m++) begin
            mid[m] = '0; maddr[m] = '0; mlen[m] = '0;
        end
        clear_model();
        // Held reset must mask a live grant and request
        mg = 2'b01; marv = 2'b01; s_ARREADY = '1;
        #2;
        chk("rst_arready", {m1_ARREADY, m0_ARREADY}, 0);
        chk("rst_s_arvalid", s_ARVALID, 0);
        chk("rst_rvalid", {m_RVALID, m1_RVALID, m0_RVALID}, 0);
        chk("rst_rlast", {m_RLAST, m1_RLAST, m0_RLAST}, 0);
        chk("rst_s_araddr", s_ARADDR, 0);
        chk("rst_rdata", m0_RDATA, 0);
        marv = 2'b00;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1; drive();

        // Mapped read, master 0 to slave 1
        beats[0] = 0; dut_mlast = 0;
        mg = 2'b01; maddr[0] = 32'h2000_0000; mlen[0] = 8'd3; mid[0] = 4'h5; marv[0] = 1'b1;
        #1;
        chk("t1_s_arvalid", s_ARVALID, 4'b0010);
        chk("t1_arready", m0_ARREADY, 1);
        step();
        run_idle(200);
        chk("t1_beats", beats[0], 4);
        chk("t1_m_rlast_count", dut_mlast, 1);

        // Unmapped read, master 1 -> DECERR
        dec_beats = 0; beats[1] = 0;
        mg = 2'b10; maddr[1] = 32'hA000_0000; mlen[1] = 8'd1; mid[1] = 4'hB; marv[1] = 1'b1;
        #1;
        chk("t2_arready", m1_ARREADY, 1);
        chk("t2_s_arvalid", s_ARVALID, 0);
        step();
        run_idle(50);
        chk("t2_dec_beats", dec_beats, 2);
        chk("t2_m1_beats", beats[1], 2);

        // Grant moves to m1 mid-burst
        mg = 2'b01; maddr[0] = 32'h0000_0010; mlen[0] = 8'd3; mid[0] = 4'h1; marv[0] = 1'b1;
        step();
        mg = 2'b10; maddr[1] = 32'h4000_0000; mlen[1] = 8'd0; mid[1] = 4'h7; marv[1] = 1'b1;
        begin
            int n;
            n = 0;
            while (active && n < 200) begin step(); n++; end
        end
        step();
        chk("t3_m1_accepted", ar_m, 1);
        chk("t3_gap", last_ar_cycle - last_r_cycle, 1);
        run_idle(200);

        // Backpressure: RREADY toggling over an 8-beat burst
        rr_mode = 2; mrr = 2'b00; beats[0] = 0;
        mg = 2'b01; maddr[0] = 32'h2000_0100; mlen[0] = 8'd7; mid[0] = 4'h3; marv[0] = 1'b1;
        step();
        run_idle(400);
        chk("t4_beats", beats[0], 8);
        rr_mode = 1;

        // Reset during the second beat of a four-beat burst
        mg = 2'b01; maddr[0] = 32'h2000_0000; mlen[0] = 8'd3; mid[0] = 4'h9; marv[0] = 1'b1;
        step();
        begin
            int n;
            n = 0;
            while (q.size() > 3 && n < 200) begin step(); n++; end
        end
        chk("t5_one_beat_done", q.size(), 3);
        #2 ARESETn = 1'b0;
        #1;
        chk("t5_s_arvalid", s_ARVALID, 0);
        chk("t5_s_rready", s_RREADY, 0);
        chk("t5_arready", {m1_ARREADY, m0_ARREADY}, 0);
        chk("t5_rvalid", {m_RVALID, m1_RVALID, m0_RVALID}, 0);
        chk("t5_rlast", {m_RLAST, m1_RLAST, m0_RLAST}, 0);
        chk("t5_rdata", m0_RDATA, 0);
        clear_model();
        @(posedge ACLK);
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1; drive();
        beats[0] = 0;
        mg = 2'b01; maddr[0] = 32'h0000_0040; mlen[0] = 8'd2; mid[0] = 4'h2; marv[0] = 1'b1;
        step();
        run_idle(200);
        chk("t5_beats_after_reset", beats[0], 3);

        // Both grants: master 0 wins; no grants: nothing forwarded
        mg = 2'b11; maddr[0] = 32'h0000_0000; maddr[1] = 32'h6000_0000;
        mlen[0] = 8'd1; mlen[1] = 8'd1; marv = 2'b11;
        #1;
        chk("t6_arready", {m1_ARREADY, m0_ARREADY}, 2'b01);
        chk("t6_s_arvalid", s_ARVALID, 4'b0001);
        step();
        run_idle(200);
        mg = 2'b00; marv = 2'b11;
        begin
            int snap;
            snap = ar_cnt;
            dut_sarv = 0;
            repeat (10) step();
            chk("t6_no_accept", ar_cnt - snap, 0);
            chk("t6_no_s_arvalid", dut_sarv, 0);
        end
        marv = 2'b00;

        // Randomised traffic
        rand_mode = 1; rr_mode = 0; sready_all = 0;
        repeat (4000) step();
        rand_mode = 0; mg = 2'b00; marv = 2'b00;
        run_idle(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axi_rd_router
`default_nettype wire
